// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec4x16_strobe sequenced decoder.
package dec_pkg;

  localparam int IDX_W = 4;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] onehot16(input logic [IDX_W-1:0] idx);
    onehot16 = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/dec4x16_strobe_if.sv
// Command handshake for dec4x16_strobe: producer is master, decoder is slave.
interface dec4x16_strobe_if
  import dec_pkg::*;
#(
  parameter int HOLD_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [IDX_W-1:0]  in_idx;
  logic [HOLD_W-1:0] in_hold;
  logic              in_sweep;

  modport master (
    output in_valid,
    output in_idx,
    output in_hold,
    output in_sweep,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_idx,
    input  in_hold,
    input  in_sweep,
    output in_ready
  );

endinterface

// File: rtl/dec4x16_comb.sv
// Pure 4-to-16 one-hot decoder; the caller registers the result.
module dec4x16_comb
  import dec_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] dec
);

  // one-hot expansion of the selected line
  always_comb begin
    dec = onehot16(idx);
  end

endmodule

// File: rtl/dec4x16_strobe.sv
// Sequenced 4-to-16 decoder: holds one line of y high for N cycles, then a fixed idle gap.
// Optional walking sweep toward line 15 is built only when SWEEP_EN is defined.
module dec4x16_strobe
  import dec_pkg::*;
#(
  parameter int HOLD_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  dec4x16_strobe_if.slave  cmd,
  output logic [OUT_W-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam int                GAP_W    = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OUT_W - 1);

  state_t            state_r;
  state_t            state_nx_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_nx_s;
  logic [HOLD_W-1:0] hold_load_s;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_nx_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nx_s;
  logic [IDX_W-1:0]  idx_inc_s;
  logic              advance_s;
  logic              accept_s;
  logic [OUT_W-1:0]  dec_s;
  logic [OUT_W-1:0]  y_r;
  logic [OUT_W-1:0]  y_nx_s;
  logic              done_r;
  logic              done_nx_s;
  logic              busy_r;
  logic              busy_nx_s;
  logic              ready_r;
  logic              ready_nx_s;

`ifdef SWEEP_EN
  logic              sweep_r;
  logic              sweep_nx_s;
  logic [HOLD_W-1:0] hold_n_r;
  logic [HOLD_W-1:0] hold_n_nx_s;

  // a sweep walks upward and stops at the last line
  assign advance_s = sweep_r && (idx_r != IDX_LAST);
  assign idx_inc_s = idx_r + IDX_W'(1);
`else
  logic              sweep_unused_s;

  assign sweep_unused_s = cmd.in_sweep;
  assign advance_s      = 1'b0;
  assign idx_inc_s      = idx_r;
`endif

  assign accept_s    = cmd.in_valid && ready_r;
  assign hold_load_s = (cmd.in_hold == '0) ? HOLD_ONE : cmd.in_hold;

  // next-state, counter and command-latch logic
  always_comb begin
    state_nx_s    = state_r;
    hold_cnt_nx_s = hold_cnt_r;
    gap_cnt_nx_s  = gap_cnt_r;
    idx_nx_s      = idx_r;
    done_nx_s     = 1'b0;
`ifdef SWEEP_EN
    sweep_nx_s    = sweep_r;
    hold_n_nx_s   = hold_n_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s    = HOLD;
          idx_nx_s      = cmd.in_idx;
          hold_cnt_nx_s = hold_load_s;
`ifdef SWEEP_EN
          sweep_nx_s    = cmd.in_sweep;
          hold_n_nx_s   = hold_load_s;
`endif
        end else begin
          state_nx_s = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_r != HOLD_ONE) begin
          hold_cnt_nx_s = hold_cnt_r - HOLD_ONE;
        end else if (advance_s) begin
          idx_nx_s = idx_inc_s;
`ifdef SWEEP_EN
          hold_cnt_nx_s = hold_n_r;
`else
          hold_cnt_nx_s = hold_cnt_r;
`endif
        end else begin
          hold_cnt_nx_s = '0;
          done_nx_s     = 1'b1;
          if (GAP_CYC == 0) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s   = GAP;
            gap_cnt_nx_s = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt_r <= GAP_ONE) begin
          state_nx_s   = IDLE;
          gap_cnt_nx_s = '0;
        end else begin
          gap_cnt_nx_s = gap_cnt_r - GAP_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they register alongside it
  assign ready_nx_s = (state_nx_s == IDLE);
  assign busy_nx_s  = (state_nx_s != IDLE);
  assign y_nx_s     = (state_nx_s == HOLD) ? dec_s : '0;

  dec4x16_comb u_dec (
    .idx (idx_nx_s),
    .dec (dec_s)
  );

  // state, counters and registered outputs; reset aborts any strobe at once
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      gap_cnt_r  <= '0;
      idx_r      <= '0;
      y_r        <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
`ifdef SWEEP_EN
      sweep_r    <= 1'b0;
      hold_n_r   <= '0;
`endif
    end else begin
      state_r    <= state_nx_s;
      hold_cnt_r <= hold_cnt_nx_s;
      gap_cnt_r  <= gap_cnt_nx_s;
      idx_r      <= idx_nx_s;
      y_r        <= y_nx_s;
      done_r     <= done_nx_s;
      busy_r     <= busy_nx_s;
      ready_r    <= ready_nx_s;
`ifdef SWEEP_EN
      sweep_r    <= sweep_nx_s;
      hold_n_r   <= hold_n_nx_s;
`endif
    end
  end

  assign y            = y_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign cmd.in_ready = ready_r;

endmodule

// File: tb/tb_dec4x16_strobe.sv
// Bench for dec4x16_strobe: two instances (GAP_CYC=1 and GAP_CYC=0) against a timeline model.
// Honours SWEEP_EN the same way the design does.
module tb_dec4x16_strobe;
  import dec_pkg::*;

  localparam int HOLD_W = 8;
  localparam int MAXC   = 8192;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid;
  logic [3:0]        idx;
  logic [HOLD_W-1:0] hold;
  logic              sweep;

  logic [15:0] y_g1;
  logic [15:0] y_g0;
  logic [1:0]  done_w;
  logic [1:0]  busy_w;
  logic [1:0]  rdy_w;

  always #5 clk = ~clk;

  dec4x16_strobe_if #(.HOLD_W(HOLD_W)) if_g1 ();
  dec4x16_strobe_if #(.HOLD_W(HOLD_W)) if_g0 ();

  assign if_g1.in_valid = valid;
  assign if_g1.in_idx   = idx;
  assign if_g1.in_hold  = hold;
  assign if_g1.in_sweep = sweep;
  assign if_g0.in_valid = valid;
  assign if_g0.in_idx   = idx;
  assign if_g0.in_hold  = hold;
  assign if_g0.in_sweep = sweep;
  assign rdy_w          = {if_g0.in_ready, if_g1.in_ready};

  dec4x16_strobe #(.HOLD_W(HOLD_W), .GAP_CYC(1)) u_g1 (
    .clk (clk), .rst (rst), .cmd (if_g1.slave),
    .y (y_g1), .busy (busy_w[0]), .done (done_w[0])
  );

  dec4x16_strobe #(.HOLD_W(HOLD_W), .GAP_CYC(0)) u_g0 (
    .clk (clk), .rst (rst), .cmd (if_g0.slave),
    .y (y_g0), .busy (busy_w[1]), .done (done_w[1])
  );

  // Expected outputs per instance, per cycle (cycle c = the period after posedge number c).
  logic [15:0] ey [2][MAXC];
  bit          ed [2][MAXC];
  bit          eb [2][MAXC];
  bit          er [2][MAXC];
  bit          in_rst [2];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int enc16(input logic [15:0] v);
    int r = -1;
    for (int b = 0; b < 16; b++) begin
      if (v[b]) r = b;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Apply the inputs about to be sampled at the next edge to the timeline model.
  task automatic model_drive();
    int c = cyc;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int j = c + 1; j < MAXC; j++) begin
          ey[i][j] = '0; ed[i][j] = 1'b0; eb[i][j] = 1'b0; er[i][j] = 1'b0;
        end
        in_rst[i] = 1'b1;
      end else if (in_rst[i]) begin
        for (int j = c + 1; j < MAXC; j++) er[i][j] = 1'b1;
        in_rst[i] = 1'b0;
      end else if (valid && er[i][c]) begin
        int a   = c + 1;
        int n   = (hold == '0) ? 1 : int'(hold);
        int pos = 1;
        int len;
        logic [15:0] v;
`ifdef SWEEP_EN
        if (sweep) pos = 16 - int'(idx);
`endif
        len = n * pos;
        for (int t = 0; t < len + gap_of(i); t++) begin
          if (a + t < MAXC) begin
            v = 16'h0001;
            eb[i][a+t] = 1'b1;
            er[i][a+t] = 1'b0;
            if (t < len) ey[i][a+t] = v << (int'(idx) + t / n);
          end
        end
        if (a + len < MAXC) ed[i][a+len] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    valid = 1'b0;
    while (!(er[0][cyc] && er[1][cyc]) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      errors++;
      $display("FAIL wait_idle timeout cyc=%0d", cyc);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("y_g1",     y_g1,      ey[0][cyc]);
      chk("done_g1",  done_w[0], ed[0][cyc]);
      chk("busy_g1",  busy_w[0], eb[0][cyc]);
      chk("ready_g1", rdy_w[0],  er[0][cyc]);
      chk("y_g0",     y_g0,      ey[1][cyc]);
      chk("done_g0",  done_w[1], ed[1][cyc]);
      chk("busy_g0",  busy_w[1], eb[1][cyc]);
      chk("ready_g0", rdy_w[1],  er[1][cyc]);
      chk("onehot_g1", ($countones(y_g1) <= 1), 1'b1);
      chk("onehot_g0", ($countones(y_g0) <= 1), 1'b1);
    end
  end

  logic [15:0] sw_exp [7];
  int          sw_done;
  logic [15:0] one;

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < MAXC; j++) ey[i][j] = '0;
      in_rst[i] = 1'b0;
    end
    valid = 1'b0; idx = 4'd0; hold = '0; sweep = 1'b0; rst = 1'b1;

    repeat (3) tick();
    chk("rst_ready_g1", rdy_w[0], 1'b0);
    chk("rst_ready_g0", rdy_w[1], 1'b0);
    chk("rst_y_g1", y_g1, 16'h0000);
    rst = 1'b0;
    tick();
    chk("post_rst_ready_g1", rdy_w[0], 1'b1);
    chk("post_rst_ready_g0", rdy_w[1], 1'b1);

    // single strobe idx=5 hold=3
    idx = 4'd5; hold = 8'd3; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("t1_y0", y_g1, 16'h0020);
    chk("t1_model", ey[0][cyc], 16'h0020);
    tick(); chk("t1_y1", y_g1, 16'h0020);
    tick(); chk("t1_y2", y_g1, 16'h0020);
    chk("t1_busy_rdy", rdy_w[0], 1'b0);
    tick();
    chk("t1_y_off", y_g1, 16'h0000);
    chk("t1_done", done_w[0], 1'b1);
    chk("t1_gap_rdy", rdy_w[0], 1'b0);
    chk("t1_g0_rdy", rdy_w[1], 1'b1);
    tick();
    chk("t1_rdy_back", rdy_w[0], 1'b1);
    chk("t1_done_off", done_w[0], 1'b0);
    wait_idle();

    // hold=0 on every index, decoded back through an encoder
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i); hold = '0; valid = 1'b1;
      tick();
      valid = 1'b0;
      one = 16'h0001;
      chk("t2_enc", enc16(y_g1), i);
      chk("t2_y", y_g1, one << i);
      tick();
      chk("t2_off", y_g1, 16'h0000);
      chk("t2_done", done_w[0], 1'b1);
      wait_idle();
    end

    // reset during the second HOLD cycle of hold=4
    idx = 4'd7; hold = 8'd4; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("t3_hold2", y_g1, 16'h0080);
    rst = 1'b1;
    tick();
    chk("t3_y", y_g1, 16'h0000);
    chk("t3_done", done_w[0], 1'b0);
    chk("t3_rdy", rdy_w[0], 1'b0);
    rst = 1'b0;
    tick();
    chk("t3_rdy_back", rdy_w[0], 1'b1);
    wait_idle();

    // back-to-back on the gap-free instance
    idx = 4'd3; hold = 8'd2; valid = 1'b1;
    tick();
    idx = 4'd4;
    chk("t4_a", y_g0, 16'h0008);
    tick(); chk("t4_b", y_g0, 16'h0008);
    tick();
    chk("t4_c", y_g0, 16'h0000);
    chk("t4_c_rdy", rdy_w[1], 1'b1);
    chk("t4_c_done", done_w[1], 1'b1);
    tick(); chk("t4_d", y_g0, 16'h0010);
    valid = 1'b0;
    tick(); chk("t4_e", y_g0, 16'h0010);
    wait_idle();

    // sweep from idx 13
`ifdef SWEEP_EN
    sw_exp = '{16'h2000, 16'h2000, 16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h0000};
    sw_done = 6;
`else
    sw_exp = '{16'h2000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    sw_done = 2;
`endif
    idx = 4'd13; hold = 8'd2; sweep = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0; sweep = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("t5_y", y_g1, sw_exp[k]);
      chk("t5_done", done_w[0], (k == sw_done));
      tick();
    end
    wait_idle();

    // sweep from idx 15 is a plain strobe
    idx = 4'd15; hold = 8'd1; sweep = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0; sweep = 1'b0;
    chk("t6_y", y_g1, 16'h8000);
    tick();
    chk("t6_off", y_g1, 16'h0000);
    chk("t6_done", done_w[0], 1'b1);
    wait_idle();

    // random traffic with back-pressure and occasional resets
    repeat (1500) begin
      rst   = ($urandom_range(0, 199) == 0);
      valid = ($urandom_range(0, 9) < 6);
      idx   = 4'($urandom);
      hold  = HOLD_W'($urandom_range(0, 4));
      sweep = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
